// File: rtl/fft_frame_unloader.sv
// fft_frame_unloader: captures whole parallel FFT frames into a two-slot
// ping-pong buffer and replays them one complex bin per cycle over a
// valid/ready stream, in natural or bit-reversed bin order.
module fft_frame_unloader #(
  parameter int N       = 32,
  parameter int DW      = 32,
  parameter bit BIT_REV = 1'b0,
  localparam int LW     = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*2*DW-1:0]    fft_out,
  input  logic                 out_valid,
  input  logic                 output_mode,
  output logic                 in_ready,
  output logic                 s_valid,
  input  logic                 s_ready,
  output logic signed [DW-1:0] s_data_r,
  output logic signed [DW-1:0] s_data_i,
  output logic [LW-1:0]        s_index,
  output logic                 s_last,
  output logic                 s_mode,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  // Frame storage: two slots of N bins, each bin {real, imag}
  logic [2*DW-1:0] slot_mem [2][N];

  logic [1:0]    full_reg, full_next;
  logic [1:0]    mode_reg;
  logic          wr_sel_reg;
  logic          rd_sel_reg;
  logic [LW-1:0] pos_reg;
  logic          overflow_reg;
  logic [15:0]   drop_count_reg;

  logic          capture;
  logic          drop;
  logic          xfer;
  logic          release_slot;
  logic          at_last;
  logic [LW-1:0] pos_rev;
  logic [LW-1:0] rd_addr;
  logic [2*DW-1:0] rd_bin;

  genvar gi;

  // Bit-reversed stream position, used as read address in BIT_REV mode
  generate
    for (gi = 0; gi < LW; gi++) begin : g_rev
      assign pos_rev[gi] = pos_reg[LW-1-gi];
    end
  endgenerate

  assign in_ready     = ~(full_reg[0] & full_reg[1]);
  assign s_valid      = full_reg[rd_sel_reg];
  assign capture      = out_valid & in_ready;
  assign drop         = out_valid & ~in_ready;
  assign xfer         = s_valid & s_ready;
  assign at_last      = (pos_reg == LW'(N-1));
  assign release_slot = xfer & at_last;
  assign rd_addr      = BIT_REV ? pos_rev : pos_reg;
  assign rd_bin       = slot_mem[rd_sel_reg][rd_addr];

  // Next full flags: release of the streamed slot and capture into the free one
  always_comb begin
    full_next = full_reg;
    if (release_slot) full_next[rd_sel_reg] = 1'b0;
    if (capture)      full_next[wr_sel_reg] = 1'b1;
  end

  // Frame data write; contents need no reset since full flags gate their use
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int j = 0; j < N; j++) begin
        slot_mem[wr_sel_reg][j] <= fft_out[j*2*DW +: 2*DW];
      end
    end
  end

  // Control state: slot flags, selectors, stream position, drop accounting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_reg       <= 2'b00;
      mode_reg       <= 2'b00;
      wr_sel_reg     <= 1'b0;
      rd_sel_reg     <= 1'b0;
      pos_reg        <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 16'h0000;
    end else begin
      full_reg <= full_next;
      if (capture) begin
        mode_reg[wr_sel_reg] <= output_mode;
        wr_sel_reg           <= ~wr_sel_reg;
      end
      if (xfer) begin
        pos_reg <= pos_reg + 1'b1;
      end
      if (release_slot) begin
        rd_sel_reg <= ~rd_sel_reg;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF) begin
          drop_count_reg <= drop_count_reg + 16'd1;
        end
      end
    end
  end

  // Stream outputs are forced to zero whenever no frame is being presented
  always_comb begin
    s_data_r = '0;
    s_data_i = '0;
    s_index  = '0;
    s_last   = 1'b0;
    s_mode   = 1'b0;
    if (s_valid) begin
      s_data_r = rd_bin[2*DW-1:DW];
      s_data_i = rd_bin[DW-1:0];
      s_index  = rd_addr;
      s_last   = at_last;
      s_mode   = mode_reg[rd_sel_reg];
    end
  end

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule
